rx_pkt_fifo_stat: RTL
=====================

RX_PKT_FIFO_STAT -- requirements
Module: rx_pkt_fifo_stat

Interface
REQ-001 Parameter EXP_LEN, default 16, is the expected packet length in valid beats, legal range 1..4095.
REQ-002 user_clk  in  1  is the single clock; all logic SHALL be rising-edge user_clk.
REQ-003 user_rst  in  1  is the reset: synchronous to user_clk, active-high.
REQ-004 rx_valid  in  1  means one receive-FIFO beat is present this cycle.
REQ-005 rx_eof  in  1  marks the last beat of a packet; it is qualified by rx_valid.
REQ-006 rx_overrun  in  1  is the receive-FIFO overflow indication, active for one or more cycles.
REQ-007 clr  in  1  is a single-cycle request to clear the statistics.
REQ-008 status_out  out  32  is the status word that feeds the software register's user_data_in.
REQ-009 pkt_strobe  out  1  is a one-cycle pulse for each packet that is counted as good.

Function
REQ-010 The state machine SHALL have three states, encoded IDLE=0, PKT=1 and DROP=2.
REQ-011 In IDLE, rx_valid with rx_eof low SHALL set len=1 and move to PKT.
REQ-012 In IDLE, rx_valid with rx_eof high SHALL complete a 1-beat packet and stay in IDLE.
REQ-013 In PKT, each rx_valid beat SHALL increment len.
- len saturates at 4095.
REQ-014 In PKT, rx_valid with rx_eof high SHALL complete the packet and return to IDLE.
REQ-015 On rx_overrun in any state, the SHALL set the overrun sticky bit.
REQ-016 On rx_overrun in PKT, or in IDLE with rx_valid high and rx_eof low, the block SHALL move to DROP.
- The in-flight packet is discarded and is not counted.
REQ-017 On rx_overrun in IDLE with rx_valid and rx_eof both high, the block SHALL discard that packet and stay in IDLE.
REQ-018 In DROP, the block SHALL ignore beats until rx_valid with rx_eof high, then return to IDLE.
- No count, no strobe, and last_len is not updated.
REQ-019 On packet completion, last_len SHALL load the final len, including any beat that saturated it.
REQ-020 On a good completion, pkt_cnt (16 bits) SHALL increment, wrapping from 0xFFFF to 0x0000.
REQ-021 pkt_strobe and the updated status_out SHALL appear one cycle after the eof beat (registered, latency 1).
REQ-022 status_out SHALL be packed as follows:
- [31:16] pkt_cnt
- [15:4] last_len
- [3] overrun sticky
- [2] len_err sticky
- [1:0] state
REQ-023 clr SHALL zero pkt_cnt, last_len and both sticky bits.
- clr SHALL NOT alter the state or the in-progress len.
REQ-024 When clr and a good completion occur in the same cycle, the clear applies first and then the increment, so pkt_cnt=1.
REQ-025 When clr and a sticky-set event occur in the same cycle, the set SHALL win.
REQ-026 Beats with rx_valid low SHALL have no effect; rx_eof without rx_valid SHALL be ignored.

Reset
REQ-027 While user_rst is high, the block SHALL hold state IDLE, with len, pkt_cnt, last_len, the sticky bits and pkt_strobe all 0.
- status_out is therefore 0x00000000.
REQ-028 On reset mid-packet, the packet's remaining beats SHALL be treated as a new packet starting in IDLE.

Configuration
REQ-029 With RX_PKT_FIFO_STAT_LEN_CHECK_EN defined, a completion with last_len != EXP_LEN SHALL set len_err and SHALL NOT count or strobe.
REQ-030 Without RX_PKT_FIFO_STAT_LEN_CHECK_EN, every non-dropped completion SHALL be good.
- status_out[2] is tied to 0.
- EXP_LEN is unused.

Verification
REQ-031 Reset, then three 16-beat packets (EXP_LEN=16) -> three pkt_strobe pulses; status_out=0x00030100.
REQ-032 rx_overrun on beat 5 of a 16-beat packet, then a good 16-beat packet -> first packet dropped; status_out=0x00010108.
REQ-033 A 15-beat packet with LEN_CHECK_EN defined -> no strobe; status_out=0x000000F4. Without the macro -> status_out=0x000100F0.
REQ-034 Preload pkt_cnt=0xFFFF, then one good packet -> status_out[31:16]=0x0000; pkt_strobe pulses once.
REQ-035 clr in the same cycle as a good eof beat, with pkt_cnt=7 -> pkt_cnt=1.
REQ-036 user_rst asserted on beat 8, then 16 more beats ending with eof -> pkt_cnt=1; last_len=16.

Source files
------------

// File: rtl/rx_pkt_fifo_stat_if.sv
// Receive-FIFO statistics bus: beat/eof/overrun/clear inputs toward the
// statistics block and the status word plus good-packet strobe back out.
interface rx_pkt_fifo_stat_if;
  logic        rx_valid;
  logic        rx_eof;
  logic        rx_overrun;
  logic        clr;
  logic [31:0] status_out;
  logic        pkt_strobe;

  modport master (
    output rx_valid, rx_eof, rx_overrun, clr,
    input  status_out, pkt_strobe
  );

  modport slave (
    input  rx_valid, rx_eof, rx_overrun, clr,
    output status_out, pkt_strobe
  );
endinterface

// File: rtl/rx_pkt_fifo_stat.sv
// rx_pkt_fifo_stat: tracks packets leaving a receive FIFO, counts good
// packets, remembers the last packet length and keeps sticky overrun and
// length-error flags, all packed into one 32-bit status word.
// Optional feature macro: RX_PKT_FIFO_STAT_LEN_CHECK_EN -- when defined, a
// completed packet whose length differs from EXP_LEN raises len_err and is
// not counted or strobed.
module rx_pkt_fifo_stat #(
  parameter int EXP_LEN = 16
) (
  input logic               user_clk,
  input logic               user_rst,
  rx_pkt_fifo_stat_if.slave bus
);

`ifdef RX_PKT_FIFO_STAT_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  localparam logic [11:0] EXP_LEN_W = 12'(EXP_LEN);
  localparam logic [11:0] LEN_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] len;
  logic [11:0] last_len;
  logic [15:0] pkt_cnt;
  logic        overrun_sticky;
  logic        len_err_sticky;
  logic        strobe_q;

  logic        eof_beat;
  logic [11:0] final_len;
  logic        complete;
  logic        len_bad;
  logic        good;

  // Decode this cycle's beat: the length the packet would end with, whether
  // a packet completes (not dropped), and whether that completion is good.
  always_comb begin
    eof_beat  = bus.rx_valid && bus.rx_eof;
    final_len = 12'd1;
    if (state != IDLE) begin
      final_len = (len == LEN_MAX) ? len : len + 12'd1;
    end
    complete  = eof_beat && !bus.rx_overrun && (state != DROP);
    len_bad   = LEN_CHECK && (final_len != EXP_LEN_W);
    good      = complete && !len_bad;
  end

  // Packet framing state machine and running beat length.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= IDLE;
      len   <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rx_valid && !bus.rx_eof) begin
            len   <= 12'd1;
            state <= bus.rx_overrun ? DROP : PKT;
          end
        end
        PKT: begin
          if (bus.rx_overrun) begin
            state <= DROP;
          end else if (bus.rx_valid) begin
            len <= final_len;
            if (bus.rx_eof) begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (eof_beat) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics: clear first, then completion updates; sticky sets beat clear.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      pkt_cnt        <= 16'd0;
      last_len       <= 12'd0;
      overrun_sticky <= 1'b0;
      len_err_sticky <= 1'b0;
      strobe_q       <= 1'b0;
    end else begin
      strobe_q <= good;
      if (bus.clr) begin
        pkt_cnt  <= 16'd0;
        last_len <= 12'd0;
      end
      if (complete) begin
        last_len <= final_len;
      end
      if (good) begin
        pkt_cnt <= bus.clr ? 16'd1 : pkt_cnt + 16'd1;
      end
      overrun_sticky <= bus.rx_overrun || (overrun_sticky && !bus.clr);
      len_err_sticky <= (complete && len_bad) || (len_err_sticky && !bus.clr);
    end
  end

  assign bus.pkt_strobe = strobe_q;
  assign bus.status_out = {pkt_cnt, last_len, overrun_sticky,
                           len_err_sticky && LEN_CHECK, state};

endmodule
